// File: rtl/vga_pkg.sv
// Shared VGA definitions: arbiter state encoding, 3-bit RGB colour constants
// and the default screen geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int SCREEN_WIDTH_DEF  = 160;
  localparam int SCREEN_HEIGHT_DEF = 120;

  // Colour is {R, G, B}
  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

endpackage

// File: rtl/pixel_arbiter.sv
// Two-client pixel arbiter feeding a VGA adapter pixel port, with burst-limited
// round-robin, per-client lock and inline bounds check with a drop counter.
//
// state  | meaning
// IDLE   | no client granted, waiting for a valid
// GRANT0 | client 0 owns the pixel port (ready0 high)
// GRANT1 | client 1 owns the pixel port (ready1 high)
module pixel_arbiter
  import vga_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int MAX_BURST     = 16
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [2:0] colour0,
  input  logic [2:0] colour1,
  input  logic       lock0,
  input  logic       lock1,
  output logic       ready0,
  output logic       ready1,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] drop_cnt
);

  localparam int              BW         = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [8:0]      X_LIM      = 9'(SCREEN_WIDTH);
  localparam logic [7:0]      Y_LIM      = 8'(SCREEN_HEIGHT);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic [7:0]    drop_q, drop_d;

  logic          xfer0, xfer1, xfer;
  logic [7:0]    win_x;
  logic [6:0]    win_y;
  logic [2:0]    win_colour;
  logic          in_bounds;

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid0 && valid1) state_d = last_q ? GRANT0 : GRANT1;
        else if (valid0)      state_d = GRANT0;
        else if (valid1)      state_d = GRANT1;
      end
      GRANT0: begin
        if (!lock0) begin
          if (valid0) begin
            if (burst_q == BURST_LAST && valid1) state_d = GRANT1;
          end else begin
            state_d = valid1 ? GRANT1 : IDLE;
          end
        end
      end
      GRANT1: begin
        if (!lock1) begin
          if (valid1) begin
            if (burst_q == BURST_LAST && valid0) state_d = GRANT0;
          end else begin
            state_d = valid0 ? GRANT0 : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready0 = (state_q == GRANT0);
    ready1 = (state_q == GRANT1);
  end

  always_comb begin
    last_d = last_q;
    if (state_d == GRANT0) last_d = 1'b0;
    if (state_d == GRANT1) last_d = 1'b1;

    // Under lock the counter parks at the limit so release switches on the next transfer
    burst_d = burst_q;
    if (state_d != state_q)               burst_d = '0;
    else if (xfer && burst_q != BURST_LAST) burst_d = burst_q + BW'(1);
  end

  always_comb begin
    xfer0      = valid0 && ready0;
    xfer1      = valid1 && ready1;
    xfer       = xfer0 || xfer1;
    win_x      = xfer1 ? x1 : x0;
    win_y      = xfer1 ? y1 : y0;
    win_colour = xfer1 ? colour1 : colour0;
    in_bounds  = ({1'b0, win_x} < X_LIM) && ({1'b0, win_y} < Y_LIM);

    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    drop_d   = drop_q;
    if (xfer) begin
      if (in_bounds) begin
        x_d      = win_x;
        y_d      = win_y;
        colour_d = win_colour;
        plot_d   = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      drop_q   <= drop_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Self-checking bench for pixel_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_pixel_arbiter;
  import vga_pkg::*;

  localparam int MAXB = 16;
  localparam int W    = 160;
  localparam int H    = 120;

  logic       clk = 1'b0;
  logic       resetb;
  logic       vin [2];
  logic       lin [2];
  logic [7:0] xin [2];
  logic [6:0] yin [2];
  logic [2:0] cin [2];
  logic       ready0, ready1, plot;
  logic [7:0] x, drop_cnt;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

  // Reference model: owner -1 = nobody, run = transfers in the current grant
  int   m_owner, m_last, m_run, m_x, m_y, m_c, m_drop;
  logic m_plot;

  always #5 clk = ~clk;

  pixel_arbiter #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .MAX_BURST(MAXB)) dut (
    .clk(clk), .resetb(resetb),
    .valid0(vin[0]), .valid1(vin[1]),
    .x0(xin[0]), .x1(xin[1]), .y0(yin[0]), .y1(yin[1]),
    .colour0(cin[0]), .colour1(cin[1]),
    .lock0(lin[0]), .lock1(lin[1]),
    .ready0(ready0), .ready1(ready1),
    .x(x), .y(y), .colour(colour), .plot(plot), .drop_cnt(drop_cnt)
  );

  function automatic void model_reset();
    m_owner = -1; m_last = 1; m_run = 0; m_plot = 1'b0;
    m_x = 0; m_y = 0; m_c = 0; m_drop = 0;
  endfunction

  function automatic void model_step();
    int  nxt;
    int  o;
    bit  xfer;
    if (resetb) begin
      model_reset();
      return;
    end
    xfer   = (m_owner == 0 && vin[0]) || (m_owner == 1 && vin[1]);
    m_plot = 1'b0;
    if (xfer) begin
      o = m_owner;
      if (int'(xin[o]) < W && int'(yin[o]) < H) begin
        m_plot = 1'b1; m_x = xin[o]; m_y = yin[o]; m_c = cin[o];
      end else if (m_drop < 255) begin
        m_drop = m_drop + 1;
      end
    end
    if (m_owner < 0) begin
      if (vin[0] && vin[1]) nxt = 1 - m_last;
      else if (vin[0])      nxt = 0;
      else if (vin[1])      nxt = 1;
      else                  nxt = -1;
    end else begin
      o = m_owner;
      if (lin[o])      nxt = o;
      else if (vin[o]) nxt = (m_run >= MAXB - 1 && vin[1-o]) ? 1 - o : o;
      else             nxt = vin[1-o] ? 1 - o : -1;
    end
    if (nxt != m_owner) begin
      m_run = 0;
      if (nxt >= 0) m_last = nxt;
    end else if (xfer) begin
      m_run = m_run + 1;
    end
    m_owner = nxt;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 2; c++) begin
      vin[c] = 1'b0; lin[c] = 1'b0; xin[c] = '0; yin[c] = '0; cin[c] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    resetb = 1'b1;
    tick();
    tick();
    resetb = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetb = 1'b1;
    tick();
    tick();
    checks++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", ready0, ready1);
    end
    checks++;
    if (plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got plot=%b x=%0d y=%0d c=%0d drop=%0d expected all 0",
                         plot, x, y, colour, drop_cnt);
    end
    resetb = 1'b0;
  endtask

  task automatic test_single_client();
    do_reset();
    vin[0] = 1'b1; xin[0] = 8'd0; yin[0] = 7'd0; cin[0] = RED;
    checks++;
    if (ready0 !== 1'b0) begin
      errors++; $display("FAIL single_ready_c0: got %b expected 0", ready0);
    end
    tick();
    checks++;
    if (ready0 !== 1'b1 || plot !== 1'b0) begin
      errors++; $display("FAIL single_ready_c1: got ready0=%b plot=%b expected 1 0", ready0, plot);
    end
    for (int k = 0; k < 5; k++) begin
      xin[0] = 8'(k);
      tick();
      checks++;
      if (plot !== 1'b1 || x !== 8'(k) || y !== 7'd0 || colour !== RED) begin
        errors++; $display("FAIL single_pixel%0d: got plot=%b x=%0d y=%0d c=%0d expected 1 %0d 0 %0d",
                           k, plot, x, y, colour, k, RED);
      end
    end
    vin[0] = 1'b0;
    tick();
    checks++;
    if (plot !== 1'b0 || drop_cnt !== 8'd0 || x !== 8'd4) begin
      errors++; $display("FAIL single_after: got plot=%b drop=%0d x=%0d expected 0 0 4", plot, drop_cnt, x);
    end
  endtask

  task automatic test_alternate();
    int exp_c;
    do_reset();
    vin[0] = 1'b1; vin[1] = 1'b1;
    yin[0] = 7'd10; yin[1] = 7'd10; cin[0] = RED; cin[1] = BLUE;
    tick();
    for (int i = 0; i < 64; i++) begin
      exp_c  = (i / MAXB) % 2;
      xin[0] = 8'(i);
      xin[1] = 8'(64 + i);
      checks++;
      if (ready0 !== (exp_c == 0) || ready1 !== (exp_c == 1)) begin
        errors++; $display("FAIL alt_grant%0d: got %b%b expected client %0d", i, ready0, ready1, exp_c);
      end
      tick();
      checks++;
      if (plot !== 1'b1 || x !== 8'(exp_c == 1 ? 64 + i : i)) begin
        errors++; $display("FAIL alt_plot%0d: got plot=%b x=%0d expected 1 %0d",
                           i, plot, x, exp_c == 1 ? 64 + i : i);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    vin[0] = 1'b1; vin[1] = 1'b1; lin[0] = 1'b1;
    xin[0] = 8'd7; xin[1] = 8'd9; yin[0] = 7'd1; yin[1] = 7'd2;
    tick();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
        errors++; $display("FAIL lock_grant%0d: got %b%b expected 10", i, ready0, ready1);
      end
      tick();
      checks++;
      if (plot !== 1'b1 || x !== 8'd7) begin
        errors++; $display("FAIL lock_plot%0d: got plot=%b x=%0d expected 1 7", i, plot, x);
      end
    end
    lin[0] = 1'b0;
    checks++;
    if (ready0 !== 1'b1) begin
      errors++; $display("FAIL lock_release: got ready0=%b expected 1", ready0);
    end
    tick();
    checks++;
    if (ready0 !== 1'b0 || ready1 !== 1'b1) begin
      errors++; $display("FAIL lock_switch: got %b%b expected 01", ready0, ready1);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_bounds();
    do_reset();
    vin[1] = 1'b1; xin[1] = 8'd160; yin[1] = 7'd5; cin[1] = GREEN;
    tick();
    checks++;
    if (ready1 !== 1'b1) begin
      errors++; $display("FAIL bounds_grant: got ready1=%b expected 1", ready1);
    end
    tick();
    checks++;
    if (plot !== 1'b0 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL bounds_x160: got plot=%b drop=%0d expected 0 1", plot, drop_cnt);
    end
    xin[1] = 8'd10; yin[1] = 7'd120;
    tick();
    checks++;
    if (plot !== 1'b0 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL bounds_y120: got plot=%b drop=%0d expected 0 2", plot, drop_cnt);
    end
    xin[1] = 8'd159; yin[1] = 7'd119;
    tick();
    checks++;
    if (plot !== 1'b1 || x !== 8'd159 || y !== 7'd119 || colour !== GREEN || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL bounds_corner: got plot=%b x=%0d y=%0d c=%0d drop=%0d expected 1 159 119 %0d 2",
                         plot, x, y, colour, drop_cnt, GREEN);
    end
    xin[1] = 8'd200;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 251) begin
        checks++;
        if (drop_cnt !== 8'd254) begin
          errors++; $display("FAIL bounds_drop254: got %0d expected 254", drop_cnt);
        end
      end
      if (i == 252) begin
        checks++;
        if (drop_cnt !== 8'd255) begin
          errors++; $display("FAIL bounds_drop255: got %0d expected 255", drop_cnt);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd255 || plot !== 1'b0 || x !== 8'd159) begin
      errors++; $display("FAIL bounds_saturate: got drop=%0d plot=%b x=%0d expected 255 0 159",
                         drop_cnt, plot, x);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    vin[1] = 1'b1; xin[1] = 8'd5; yin[1] = 7'd6; cin[1] = WHITE;
    tick();
    tick();
    tick();
    checks++;
    if (ready1 !== 1'b1 || plot !== 1'b1) begin
      errors++; $display("FAIL midrst_burst: got ready1=%b plot=%b expected 1 1", ready1, plot);
    end
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    checks++;
    if (plot !== 1'b0 || ready0 !== 1'b0 || ready1 !== 1'b0 || x !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_after: got plot=%b ready=%b%b x=%0d drop=%0d expected 0 00 0 0",
                         plot, ready0, ready1, x, drop_cnt);
    end
    vin[0] = 1'b1;
    tick();
    checks++;
    if (ready0 !== 1'b1 || ready1 !== 1'b0) begin
      errors++; $display("FAIL midrst_tie: got %b%b expected 10", ready0, ready1);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      resetb = ($urandom_range(199) == 0);
      for (int c = 0; c < 2; c++) begin
        vin[c] = ($urandom_range(3) != 0);
        lin[c] = ($urandom_range(15) == 0);
        xin[c] = 8'($urandom_range(199));
        yin[c] = 7'($urandom_range(127));
        cin[c] = 3'($urandom_range(7));
      end
      checks++;
      if (ready0 !== (m_owner == 0) || ready1 !== (m_owner == 1)) begin
        errors++; $display("FAIL rand_ready%0d: got %b%b expected owner %0d", i, ready0, ready1, m_owner);
      end
      tick();
      checks++;
      if (plot !== m_plot || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_plot%0d: got plot=%b drop=%0d expected %b %0d",
                           i, plot, drop_cnt, m_plot, m_drop);
      end
      if (m_plot) begin
        checks++;
        if (x !== 8'(m_x) || y !== 7'(m_y) || colour !== 3'(m_c)) begin
          errors++; $display("FAIL rand_pixel%0d: got %0d,%0d,%0d expected %0d,%0d,%0d",
                             i, x, y, colour, m_x, m_y, m_c);
        end
      end
    end
    resetb = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    resetb = 1'b1;
    test_reset();
    test_single_client();
    test_alternate();
    test_lock();
    test_bounds();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
